// File: rtl/bcd_serial_adder.sv
// Digit-serial N-digit BCD adder: walks latched operands through one
// single-digit bcd_adder, LSD first, then pulses done with the packed sum.

module bcd_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        cout = raw > 5'd9;
        sum  = cout ? raw[3:0] + 4'd6 : raw[3:0];
    end
endmodule

module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a_in,
    input  logic [4*DIGITS-1:0]   b_in,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [4*DIGITS-1:0]   sum_out,
    output logic                  cout
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  a_q, b_q, sum_q;
    logic          c_q, cout_q, err_q;
    logic [IW-1:0] idx;
    logic [3:0]    d_sum;
    logic          d_cout;
    logic          bad;

    function automatic logic has_bad(input logic [W-1:0] x);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (x[4*i +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    assign bad = has_bad(a_in) | has_bad(b_in);

    bcd_adder u_digit (
        .a    (a_q[4*idx +: 4]),
        .b    (b_q[4*idx +: 4]),
        .cin  (c_q),
        .sum  (d_sum),
        .cout (d_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = bad ? FIN : ADD;
            ADD:  if (idx == LAST) state_nx = FIN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Result registers are cleared on accept so the err path reports zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                a_q    <= a_in;
                b_q    <= b_in;
                c_q    <= cin;
                idx    <= '0;
                sum_q  <= '0;
                cout_q <= 1'b0;
                err_q  <= bad;
            end else if (state == ADD) begin
                sum_q[4*idx +: 4] <= d_sum;
                c_q               <= d_cout;
                idx               <= idx + IW'(1);
                if (idx == LAST) cout_q <= d_cout;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == FIN);
    assign err     = err_q;
    assign sum_out = sum_q;
    assign cout    = cout_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4): vector table,
// result scoreboard, and hand sequences for busy-start, back-to-back, reset.

module tb_bcd_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        cin = 1'b0;
    logic        busy, done, err, cout;
    logic [15:0] sum_out;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] sum;
        logic        co;
        logic        er;
        int          lat;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[10];

    bcd_serial_adder #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_in(a_in), .b_in(b_in), .cin(cin),
        .busy(busy), .done(done), .err(err),
        .sum_out(sum_out), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("sum", 32'(sum_out), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.co));
                check("err", 32'(err), 32'(e.er));
            end
        end
    end

    function automatic vec_t mk(input logic [15:0] a, b, input logic c,
                                input logic [15:0] s, input logic co, er);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.sum = s; v.co = co; v.er = er;
        v.lat = er ? 1 : 5;
        return v;
    endfunction

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_op(input vec_t v);
        int cyc;
        @(negedge clk);
        a_in = v.a; b_in = v.b; cin = v.c; start = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a_in = 16'($urandom); b_in = 16'($urandom); cin = 1'($urandom);
        check("busy_c1", 32'(busy), 32'(1));
        wait_done(cyc);
        check("latency", 32'(cyc), 32'(v.lat));
        @(negedge clk);
        check("done_drop", 32'({done, busy}), 32'(0));
        check("sum_hold", 32'({cout, sum_out}), 32'({v.co, v.sum}));
    endtask

    initial begin
        int cyc;
        int first, second;
        vecs[0] = mk(16'h0457, 16'h0385, 1'b0, 16'h0842, 1'b0, 1'b0);
        vecs[1] = mk(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        vecs[2] = mk(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
        vecs[3] = mk(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        vecs[4] = mk(16'h0008, 16'h0008, 1'b0, 16'h0016, 1'b0, 1'b0);
        vecs[5] = mk(16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
        vecs[6] = mk(16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1, 1'b0);
        vecs[7] = mk(16'h0005, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b1);
        vecs[8] = mk(16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0);
        vecs[9] = mk(16'h2468, 16'h1357, 1'b1, 16'h3826, 1'b0, 1'b0);

        #12;
        check("rst_outs", 32'({busy, done, err, cout, sum_out}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) do_op(vecs[i]);

        // start pulsed while busy must be ignored
        @(negedge clk);
        a_in = 16'h0457; b_in = 16'h0385; cin = 1'b0; start = 1'b1;
        sb.push_back(vecs[0]);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a_in = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 3;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_start_lat", 32'(cyc), 32'(5));
        @(negedge clk);

        // start held through FIN: next op accepted on the IDLE edge
        a_in = 16'h0008; b_in = 16'h0008; cin = 1'b0; start = 1'b1;
        sb.push_back(vecs[4]);
        @(posedge clk);
        first = 0; second = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a_in = 16'h0001; b_in = 16'h0001;
                sb.push_back(mk(16'h0001, 16'h0001, 1'b0, 16'h0002,
                                1'b0, 1'b0));
            end
            if (c == 7) start = 1'b0;
            if (done && first == 0) first = c;
            else if (done && second == 0) second = c;
        end
        check("b2b_first", 32'(first), 32'(5));
        check("b2b_second", 32'(second), 32'(11));

        // async reset in cycle 3 of ADD aborts with no done
        @(negedge clk);
        a_in = 16'h0457; b_in = 16'h0385; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_abort", 32'({busy, done, err, cout, sum_out}), 32'(0));
        repeat (3) @(negedge clk);
        check("rst_hold", 32'({busy, done, sum_out}), 32'(0));
        rst_n = 1'b1;
        do_op(mk(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0));

        repeat (8) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
